pattern_serializer: RTL and testbench

- Serial bit-stream transmitter that drives single-bit pattern streams into the lab's serial sequence detectors, one bit per clock.
- Accepts a parallel word, a bit length and a repeat count, then shifts the word out MSB-first on b with a start/busy/done handshake.
- Keeps a built-in expected-match counter: the number of overlapping "001"/"010" triples it has transmitted. The bench compares this against the detector's w pulses.

---
 rtl/pattern_serializer.sv | 156 +++++++++++++++
 tb/tb_pattern_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer
// Shifts a parallel pattern out MSB-first on a single registered bit line.
// The pattern can be repeated back to back with no gap. While the bits go
// out, the block counts the overlapping "001"/"010" triples it sends, so a
// downstream sequence detector's match pulses can be checked against it.

module pattern_serializer #(
    parameter int WIDTH = 8,   // maximum pattern length in bits
    parameter int LEN_W = 4,   // width of len; 2**LEN_W must exceed WIDTH
    parameter int REP_W = 4,   // width of reps
    parameter int CNT_W = 4    // width of the saturating match counter
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             b,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    // The shift store is as wide as len can address, so any bit index held
    // in LEN_W bits selects a real bit. The bits above WIDTH are always zero.
    localparam int               SH_W    = 2 ** LEN_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [SH_W-1:0]  shreg;      // latched pattern, zero-extended
    logic [LEN_W-1:0] len_q;      // effective (clamped) length of this transfer
    logic [LEN_W-1:0] idx;        // index of the bit currently on b
    logic [REP_W-1:0] reps_left;  // repetitions still to send after this one
    logic [1:0]       hist;       // {older, newer} of the two last launched bits
    logic [1:0]       hist_cnt;   // bits launched so far this transfer, capped at 2

    // Values used at the accept edge
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] first_idx;
    logic [SH_W-1:0]  data_ext;
    logic             first_bit;

    // Values used at each SHIFT edge
    logic             last_bit;
    logic [LEN_W-1:0] next_idx;
    logic             next_bit;
    logic             next_match;

    // Clamp the requested length and pick the first (most significant) bit.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a path
        // that leaves one unassigned turns it into a latch.
        eff_len   = (len > MAX_LEN) ? MAX_LEN : len;
        first_idx = eff_len - LEN_W'(1);
        data_ext  = SH_W'(data);
        first_bit = data_ext[first_idx];
    end

    // Work out the bit to launch next, wrapping to the top of the pattern
    // at a repetition boundary, and whether it closes a counted triple.
    always_comb begin
        last_bit   = (idx == '0) && (reps_left == '0);
        next_idx   = (idx != '0) ? (idx - LEN_W'(1)) : (len_q - LEN_W'(1));
        next_bit   = shreg[next_idx];
        next_match = (hist_cnt == 2'd2) &&
                     (({hist, next_bit} == 3'b001) || ({hist, next_bit} == 3'b010));
    end

    // Control FSM with registered outputs, the shift datapath and the match counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side reads the value from before this edge.
        if (rst) begin
            state     <= IDLE;
            b         <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
            shreg     <= '0;
            len_q     <= '0;
            idx       <= '0;
            reps_left <= '0;
            hist      <= '0;
            hist_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    b     <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    // A zero length is not a transfer: stay idle and never pulse done.
                    if (start && (len != '0)) begin
                        shreg     <= data_ext;
                        len_q     <= eff_len;
                        idx       <= first_idx;
                        reps_left <= reps;
                        // History restarts per transfer. The first bit is already in it.
                        hist      <= {1'b0, first_bit};
                        hist_cnt  <= 2'd1;
                        match_cnt <= '0;
                        b         <= first_bit;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (last_bit) begin
                        b     <= 1'b1;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx  <= next_idx;
                        if (idx == '0) begin
                            reps_left <= reps_left - REP_W'(1);
                        end
                        b    <= next_bit;
                        hist <= {hist[0], next_bit};
                        if (hist_cnt != 2'd2) begin
                            hist_cnt <= hist_cnt + 2'd1;
                        end
                        if (next_match && (match_cnt != CNT_MAX)) begin
                            match_cnt <= match_cnt + CNT_W'(1);
                        end
                    end
                end

                DONE: begin
                    // A start seen here is dropped on purpose. The next
                    // transfer can only begin from IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Testbench for pattern_serializer.
// A driver issues transfers and pushes the expected bit stream and the
// expected final match count into queues. A monitor pops and compares them
// whenever the DUT shows valid or done.

module tb_pattern_serializer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] reps;
    logic       b;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] match_cnt;

    int checks   = 0;
    int failures = 0;

    bit exp_bits[$];
    int exp_cnt[$];
    int last_cnt = 0;

    pattern_serializer #(
        .WIDTH(8),
        .LEN_W(4),
        .REP_W(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .len      (len),
        .reps     (reps),
        .b        (b),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list every bit of the transfer, then count the
    // 001/010 windows over that list and saturate the count at 15.
    task automatic model_push(input logic [7:0] d, input int l, input int r);
        bit seq[$];
        int eff;
        int cnt;
        logic [2:0] tri_bits;
        eff = (l > 8) ? 8 : l;
        for (int rr = 0; rr <= r; rr++) begin
            for (int i = eff - 1; i >= 0; i--) begin
                seq.push_back(d[i[2:0]]);
            end
        end
        cnt = 0;
        for (int i = 2; i < seq.size(); i++) begin
            tri_bits = {seq[i-2], seq[i-1], seq[i]};
            if (tri_bits == 3'b001 || tri_bits == 3'b010) cnt++;
        end
        if (cnt > 15) cnt = 15;
        foreach (seq[i]) exp_bits.push_back(seq[i]);
        exp_cnt.push_back(cnt);
        last_cnt = cnt;
    endtask

    // Monitor: compare each presented bit and each final count with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                check("busy_with_valid", 32'(busy), 1);
                check("bit_expected", 32'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) check("b", 32'(b), 32'(exp_bits.pop_front()));
            end
            if (done) begin
                check("valid_in_done", 32'(valid), 0);
                check("cnt_expected", 32'(exp_cnt.size() > 0), 1);
                if (exp_cnt.size() > 0) check("match_cnt", 32'(match_cnt), 32'(exp_cnt.pop_front()));
            end
        end
    end

    // Run one transfer. poke_at / rst_at give the cycle after acceptance
    // whose edge samples a stray start or a reset (0 = none).
    // Every call starts and ends 1 time unit after a negedge.
    task automatic run_xfer(input logic [7:0] d, input int l, input int r,
                            input int poke_at, input int rst_at);
        int  n;
        int  eff;
        bit  seen;
        data  = d;
        len   = 4'(l);
        reps  = 4'(r);
        start = 1'b1;
        if (l == 0) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("len0_busy", 32'(busy), 0);
                check("len0_done", 32'(done), 0);
                check("len0_valid", 32'(valid), 0);
            end
            #1 start = 1'b0;
            return;
        end
        model_push(d, l, r);
        eff  = (l > 8) ? 8 : l;
        n    = eff * (r + 1);
        seen = 1'b0;
        for (int cyc = 1; cyc <= n + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("busy_after_accept", 32'(busy), 1);
            if (done) begin
                check("done_latency", 32'(cyc), 32'(n + 1));
                check("busy_in_done", 32'(busy), 1);
                seen = 1'b1;
            end
            #1;
            start = 1'b0;
            if (cyc == poke_at) begin
                start = 1'b1;
                data  = 8'($urandom);
                len   = 4'($urandom_range(1, 8));
                reps  = 4'($urandom_range(0, 3));
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                exp_bits.delete();
                exp_cnt.delete();
                @(negedge clk);
                check("rst_b", 32'(b), 1);
                check("rst_valid", 32'(valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_match_cnt", 32'(match_cnt), 0);
                #1 rst = 1'b0;
                return;
            end
            if (seen) break;
        end
        check("done_seen", 32'(seen), 1);
        @(negedge clk);
        check("post_done_busy", 32'(busy), 0);
        check("post_done_done", 32'(done), 0);
        check("post_done_b", 32'(b), 1);
        check("match_cnt_hold", 32'(match_cnt), 32'(last_cnt));
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        len   = '0;
        reps  = '0;
        repeat (3) @(negedge clk);
        check("reset_b", 32'(b), 1);
        check("reset_valid", 32'(valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_match_cnt", 32'(match_cnt), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        run_xfer(8'h02, 4, 0, 0, 0);   // 0010, count 2
        run_xfer(8'h02, 3, 2, 0, 0);   // 010 x3, count 5
        run_xfer(8'hFF, 8, 0, 0, 0);   // all ones, count 0
        run_xfer(8'hA5, 8, 0, 3, 0);   // stray start mid-transfer
        run_xfer(8'h5A, 0, 0, 0, 0);   // zero length ignored
        run_xfer(8'h49, 8, 3, 0, 0);   // 19 raw triples, saturates at 15
        run_xfer(8'h36, 8, 0, 0, 4);   // reset mid-transfer
        run_xfer(8'h13, 5, 1, 0, 0);   // normal transfer after reset
        run_xfer(8'h0B, 12, 0, 0, 0);  // length clamped to 8

        for (int k = 0; k < 25; k++) begin
            run_xfer(8'($urandom), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), 0, 0);
        end

        check("bits_drained", 32'(exp_bits.size()), 0);
        check("cnts_drained", 32'(exp_cnt.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
